// File: rtl/image_write_if.sv
// Two-pixels-per-cycle video stream: VSYNC frame pulse, HSYNC qualifying DATA_0/DATA_1.
// The source drives through the master modport, and image_write receives through the slave modport.
interface image_write_if;
    logic       VSYNC;
    logic       HSYNC;
    logic [7:0] DATA_0;
    logic [7:0] DATA_1;

    modport master (output VSYNC, HSYNC, DATA_0, DATA_1);
    modport slave  (input  VSYNC, HSYNC, DATA_0, DATA_1);
endinterface

// File: rtl/image_write.sv
// Frame-buffer sink: captures a WIDTH x HEIGHT 8-bit frame from the pixel stream and has a registered read port.
// Define IMAGE_WRITE_ROW_FLIP_EN to store rows bottom-up, which is BMP order.
module image_write #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int ADDR_W = 17
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    image_write_if.slave      pix,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [ADDR_W:0]   pix_cnt,
    output logic              frame_done,
    output logic              overflow_err
);

    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int DEPTH  = NPIX / 2;
    localparam int PAIR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t            state;
    logic              vs_d;
    logic              vs_rise;
    logic              beat_ok;
    logic              last_pair;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] wr_row;
    logic [ADDR_W-1:0] wr_col;
    logic [ADDR_W-1:0] wr_addr;
    logic [PAIR_W-1:0] wr_idx;
    logic [PAIR_W-1:0] rd_idx;
    logic              rd_in_range;

    // Each word holds an even/odd pixel pair. Column is always even, so one word write stores both pixels of a beat.
    logic [15:0] mem [DEPTH];

    // NOTE: every signal is assigned on every pass through this block, so no latch is inferred.
    always_comb begin
        vs_rise     = pix.VSYNC & ~vs_d;
        beat_ok     = pix.HSYNC & (vs_rise | (state == ARMED) | (state == CAPTURE));
        wr_row      = vs_rise ? '0 : row;
        wr_col      = vs_rise ? '0 : col;
        last_pair   = (wr_row == ADDR_W'(HEIGHT - 1)) && (wr_col == ADDR_W'(WIDTH - 2));
`ifdef IMAGE_WRITE_ROW_FLIP_EN
        wr_addr     = (ADDR_W'(HEIGHT - 1) - wr_row) * ADDR_W'(WIDTH) + wr_col;
`else
        wr_addr     = wr_row * ADDR_W'(WIDTH) + wr_col;
`endif
        wr_idx      = PAIR_W'(wr_addr >> 1);
        rd_idx      = PAIR_W'(rd_addr >> 1);
        rd_in_range = {1'b0, rd_addr} < (ADDR_W + 1)'(NPIX);
    end

    // A restart that coincides with a beat is handled as the first beat of the new frame, at row 0 and column 0.
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= IDLE;
            vs_d         <= 1'b0;
            row          <= '0;
            col          <= '0;
            pix_cnt      <= '0;
            frame_done   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            vs_d <= pix.VSYNC;
            if (beat_ok) begin
                pix_cnt    <= (vs_rise ? '0 : pix_cnt) + (ADDR_W + 1)'(2);
                frame_done <= last_pair;
                state      <= last_pair ? DONE : CAPTURE;
                if (last_pair) begin
                    row <= '0;
                    col <= '0;
                end else if (wr_col == ADDR_W'(WIDTH - 2)) begin
                    row <= wr_row + ADDR_W'(1);
                    col <= '0;
                end else begin
                    row <= wr_row;
                    col <= wr_col + ADDR_W'(2);
                end
            end else if (vs_rise) begin
                state      <= ARMED;
                row        <= '0;
                col        <= '0;
                pix_cnt    <= '0;
                frame_done <= 1'b0;
            end else if (pix.HSYNC) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // NOTE: the frame buffer is deliberately left out of reset, because only control state needs a known value.
    always_ff @(posedge HCLK) begin
        if (beat_ok) begin
            mem[wr_idx] <= {pix.DATA_1, pix.DATA_0};
        end
    end

    // A read that hits the word being written returns the pre-write contents.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_data <= '0;
        end else if (rd_in_range) begin
            rd_data <= rd_addr[0] ? mem[rd_idx][15:8] : mem[rd_idx][7:0];
        end else begin
            rd_data <= '0;
        end
    end

endmodule
